aim_trigger: RTL and testbench
==============================

AIM_TRIGGER -- requirements
Module: aim_trigger

Interface
REQ-001 SHALL have parameter DWELL_RADIUS, default 11'd16: max per-axis distance (pixels) for the aim to count as steady.
REQ-002 SHALL have parameter DWELL_FRAMES, default 4'd10: consecutive steady frames required to fire.
REQ-003 SHALL have parameter COOLDOWN_FRAMES, default 6'd30: frames held off after a fire.
REQ-004 SHALL have parameter CROSS_HALF, default 11'd8: crosshair arm half-length (pixels).
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 x  input  11  current pixel column from the scan generator.
REQ-008 y  input  11  current pixel row from the scan generator.
REQ-009 aimX  input  11  per-frame smoothed target column from the image processor (averageX).
REQ-010 aimY  input  11  per-frame smoothed target row from the image processor (averageY).
REQ-011 fire  output  1  one-clock shot pulse.
REQ-012 state  output  2  FSM state: 0 IDLE, 1 TRACK, 2 FIRE, 3 COOLDOWN.
REQ-013 dwellCount  output  4  current steady-frame count.
REQ-014 lockX  output  11  column latched at fire.
REQ-015 lockY  output  11  row latched at fire.
REQ-016 crosshairOn  output  1  registered overlay bit for pixel (x,y).

Function
REQ-017 SHALL generate internal frame tick for exactly one clock on the cycle where (x==0 && y==0) is true and was false the previous cycle; the edge register resets to 0.
REQ-018 SHALL treat aim == (0,0) as "no target".
REQ-019 SHALL compute per-axis distance as unsigned larger-minus-smaller in 11 bits (no wrap); steady = dX<=DWELL_RADIUS and dY<=DWELL_RADIUS against anchor (anchorX, anchorY).
REQ-020 IDLE: on tick with target present, anchor<=aim, dwellCount<=0, go TRACK; otherwise stay.
REQ-021 TRACK: on tick with no target, go IDLE, dwellCount<=0.
REQ-022 TRACK: on tick with target steady, if dwellCount+1==DWELL_FRAMES go FIRE, lockX/lockY<=anchor, dwellCount<=0; else dwellCount<=dwellCount+1; anchor unchanged.
REQ-023 TRACK: on tick with target not steady, anchor<=aim, dwellCount<=0, stay TRACK.
REQ-024 FIRE: SHALL last exactly one clock with fire=1 (registered), then COOLDOWN with cooldown counter<=0, independent of tick.
REQ-025 COOLDOWN: each tick increments the 6-bit cooldown counter; tick where counter+1==COOLDOWN_FRAMES goes IDLE, counter<=0; aim ignored.
REQ-026 fire SHALL be 0 in every state other than FIRE.
REQ-027 Display point SHALL be anchor in IDLE/TRACK and lock in FIRE/COOLDOWN.
REQ-028 crosshairOn SHALL be registered one clock after (x,y): 1 iff (x==dispX and |y-dispY|<=CROSS_HALF) or (y==dispY and |x-dispX|<=CROSS_HALF), same abs rule as REQ-019; display point (0,0) forces 0.
REQ-029 aimX/aimY SHALL only be sampled on tick cycles; changes between ticks have no effect.
REQ-030 Reset released on a cycle with x==0,y==0 SHALL produce a tick that cycle (edge register is 0).

Reset
REQ-031 resetn low SHALL immediately set state=IDLE, fire=0, crosshairOn=0, dwellCount=0, cooldown=0, anchor=0, lockX=0, lockY=0, edge register=0, regardless of clock.
REQ-032 Reset asserted mid-FIRE or mid-COOLDOWN SHALL abort with no further fire pulse; operation resumes from IDLE at next tick after release.

Verification
REQ-033 Aim (300,200) held 11 frames -> IDLE->TRACK at tick 1, fire=1 one clock at tick 11, lockX=300, lockY=200, state=FIRE then COOLDOWN.
REQ-034 Aim alternates (300,200)/(320,200) per frame (d=20>16) -> dwellCount stays 0, fire never asserts over 30 frames.
REQ-035 Aim (300,200) then (316,216) (d=16 boundary) -> counted steady, fire at tick 11.
REQ-036 After fire, aim held constant -> exactly 30 ticks in COOLDOWN, IDLE, TRACK next tick, second fire 10 ticks later; aim (0,0) during TRACK -> IDLE, dwellCount=0.
REQ-037 Anchor (100,50), scan full frame -> crosshairOn=1 exactly at 33 pixels (x=100,y=42..58; y=50,x=92..108), each one clock late.
REQ-038 resetn pulsed low at dwellCount=7 and in COOLDOWN -> all outputs 0 asynchronously, no fire until 10 new steady ticks.

Source files
------------

// File: rtl/aim_trigger.sv
// Aim-dwell trigger: fires one shot once the smoothed aim point stays steady for
// DWELL_FRAMES frames, then holds off for COOLDOWN_FRAMES frames; also draws a crosshair.
module aim_trigger #(
    parameter logic [10:0] DWELL_RADIUS    = 11'd16,
    parameter logic [3:0]  DWELL_FRAMES    = 4'd10,
    parameter logic [5:0]  COOLDOWN_FRAMES = 6'd30,
    parameter logic [10:0] CROSS_HALF      = 11'd8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic [10:0] aimX,
    input  logic [10:0] aimY,
    output logic        fire,
    output logic [1:0]  state,
    output logic [3:0]  dwellCount,
    output logic [10:0] lockX,
    output logic [10:0] lockY,
    output logic        crosshairOn
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_FIRE  = 2'd2;
    localparam logic [1:0] ST_COOL  = 2'd3;

    function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic [1:0]  state_q, state_d;
    logic [3:0]  dwell_q, dwell_d;
    logic [5:0]  cool_q, cool_d;
    logic [10:0] anchor_x_q, anchor_x_d, anchor_y_q, anchor_y_d;
    logic [10:0] lock_x_q, lock_x_d, lock_y_q, lock_y_d;
    logic        fire_q, fire_d;
    logic        xhair_q, xhair_d;
    logic        origin_q, origin_d;

    logic        tick, target, steady;
    logic [10:0] disp_x, disp_y;

    always_comb begin
        origin_d = (x == 11'd0) && (y == 11'd0);
        // Frame tick on the rising edge of "scan is at the origin".
        tick     = origin_d && !origin_q;
        target   = !((aimX == 11'd0) && (aimY == 11'd0));
        steady   = (abs_diff(aimX, anchor_x_q) <= DWELL_RADIUS) &&
                   (abs_diff(aimY, anchor_y_q) <= DWELL_RADIUS);

        state_d    = state_q;
        dwell_d    = dwell_q;
        cool_d     = cool_q;
        anchor_x_d = anchor_x_q;
        anchor_y_d = anchor_y_q;
        lock_x_d   = lock_x_q;
        lock_y_d   = lock_y_q;

        case (state_q)
            ST_IDLE: begin
                if (tick && target) begin
                    anchor_x_d = aimX;
                    anchor_y_d = aimY;
                    dwell_d    = 4'd0;
                    state_d    = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (tick) begin
                    if (!target) begin
                        state_d = ST_IDLE;
                        dwell_d = 4'd0;
                    end else if (steady) begin
                        if ((dwell_q + 4'd1) == DWELL_FRAMES) begin
                            state_d  = ST_FIRE;
                            lock_x_d = anchor_x_q;
                            lock_y_d = anchor_y_q;
                            dwell_d  = 4'd0;
                        end else begin
                            dwell_d = dwell_q + 4'd1;
                        end
                    end else begin
                        // Aim moved too far: restart the dwell around the new point.
                        anchor_x_d = aimX;
                        anchor_y_d = aimY;
                        dwell_d    = 4'd0;
                    end
                end
            end
            ST_FIRE: begin
                state_d = ST_COOL;
                cool_d  = 6'd0;
            end
            ST_COOL: begin
                if (tick) begin
                    if ((cool_q + 6'd1) == COOLDOWN_FRAMES) begin
                        state_d = ST_IDLE;
                        cool_d  = 6'd0;
                    end else begin
                        cool_d = cool_q + 6'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        fire_d = (state_d == ST_FIRE);

        if ((state_q == ST_IDLE) || (state_q == ST_TRACK)) begin
            disp_x = anchor_x_q;
            disp_y = anchor_y_q;
        end else begin
            disp_x = lock_x_q;
            disp_y = lock_y_q;
        end

        xhair_d = !((disp_x == 11'd0) && (disp_y == 11'd0)) &&
                  (((x == disp_x) && (abs_diff(y, disp_y) <= CROSS_HALF)) ||
                   ((y == disp_y) && (abs_diff(x, disp_x) <= CROSS_HALF)));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            dwell_q    <= 4'd0;
            cool_q     <= 6'd0;
            anchor_x_q <= 11'd0;
            anchor_y_q <= 11'd0;
            lock_x_q   <= 11'd0;
            lock_y_q   <= 11'd0;
            fire_q     <= 1'b0;
            xhair_q    <= 1'b0;
            origin_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            cool_q     <= cool_d;
            anchor_x_q <= anchor_x_d;
            anchor_y_q <= anchor_y_d;
            lock_x_q   <= lock_x_d;
            lock_y_q   <= lock_y_d;
            fire_q     <= fire_d;
            xhair_q    <= xhair_d;
            origin_q   <= origin_d;
        end
    end

    assign fire        = fire_q;
    assign state       = state_q;
    assign dwellCount  = dwell_q;
    assign lockX       = lock_x_q;
    assign lockY       = lock_y_q;
    assign crosshairOn = xhair_q;

endmodule

// File: tb/tb_aim_trigger.sv
// Bench for aim_trigger: stimulus pushes expected snapshots, shots and crosshair
// pixels into queues; one monitor on the falling edge pops and compares them.
module tb_aim_trigger;

    logic        clock;
    logic        resetn;
    logic [10:0] x, y, aimX, aimY;
    logic        fire;
    logic [1:0]  state;
    logic [3:0]  dwellCount;
    logic [10:0] lockX, lockY;
    logic        crosshairOn;

    aim_trigger dut (
        .clock(clock), .resetn(resetn), .x(x), .y(y), .aimX(aimX), .aimY(aimY),
        .fire(fire), .state(state), .dwellCount(dwellCount),
        .lockX(lockX), .lockY(lockY), .crosshairOn(crosshairOn)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // snapshot = {state, dwellCount, fire, lockX, lockY, crosshairOn}
    logic [29:0] snap_q[$];
    logic [21:0] fire_q[$];
    logic [21:0] xh_q[$];

    logic        snap;
    logic        xh_en;
    logic        done;
    logic [10:0] exp_lx, exp_ly;
    logic [21:0] pix_hist;
    int          checks;
    int          failures;
    int          cyc;

    always @(posedge clock) pix_hist <= {x, y};

    // driver tasks
    task automatic push_snap(input logic [1:0] st, input logic [3:0] dc);
        snap_q.push_back({st, dc, (st == 2'd2), exp_lx, exp_ly, 1'b0});
    endtask

    task automatic frame(input logic [10:0] ax, input logic [10:0] ay,
                         input logic [1:0] st, input logic [3:0] dc);
        x = 11'd0; y = 11'd0; aimX = ax; aimY = ay;
        @(posedge clock); #1;
        push_snap(st, dc);
        snap = 1'b1;
        x = 11'd5; y = 11'd5; aimX = 11'd0; aimY = 11'd0;
        @(posedge clock); #1;
        snap = 1'b0;
        aimX = 11'd700; aimY = 11'd10;
        @(posedge clock); #1;
    endtask

    task automatic pulse_reset();
        #2;
        resetn = 1'b0;
        exp_lx = 11'd0; exp_ly = 11'd0;
        push_snap(2'd0, 4'd0);
        snap = 1'b1;
        @(posedge clock); #1;
        snap = 1'b0;
        resetn = 1'b1;
        @(posedge clock); #1;
    endtask

    // scoreboard / monitor
    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        logic [29:0] e;
        logic [21:0] f;
        cyc++;
        if (snap) begin
            if (snap_q.size() == 0) cmp("snap_underflow", 1, 0);
            else begin
                e = snap_q.pop_front();
                cmp("state", state, e[29:28]);
                cmp("dwellCount", dwellCount, e[27:24]);
                cmp("fire", fire, e[23]);
                cmp("lockX", lockX, e[22:12]);
                cmp("lockY", lockY, e[11:1]);
                cmp("crosshairOn", crosshairOn, e[0]);
            end
        end
        if (fire) begin
            if (fire_q.size() == 0) cmp("unexpected_fire", 1, 0);
            else begin
                f = fire_q.pop_front();
                cmp("fire_lockX", lockX, f[21:11]);
                cmp("fire_lockY", lockY, f[10:0]);
                cmp("fire_state", state, 2);
            end
        end
        if (xh_en) begin
            if (crosshairOn) begin
                if (xh_q.size() == 0) cmp("xhair_extra", {pix_hist[21:11], pix_hist[10:0]}, 0);
                else begin
                    f = xh_q.pop_front();
                    cmp("xhair_pixel", pix_hist, f);
                end
            end else if (xh_q.size() != 0 && xh_q[0] == pix_hist) begin
                f = xh_q.pop_front();
                cmp("xhair_missed", 0, 1);
            end
        end
        if (done || cyc > 30000) begin
            if (!done) cmp("timeout", 0, 1);
            cmp("fire_queue_left", fire_q.size(), 0);
            cmp("snap_queue_left", snap_q.size(), 0);
            cmp("xhair_queue_left", xh_q.size(), 0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    // stimulus
    initial begin
        checks = 0; failures = 0; cyc = 0;
        snap = 1'b0; xh_en = 1'b0; done = 1'b0;
        exp_lx = 11'd0; exp_ly = 11'd0;
        resetn = 1'b0;
        x = 11'd0; y = 11'd0; aimX = 11'd300; aimY = 11'd200;
        repeat (2) @(posedge clock);
        #1;
        push_snap(2'd0, 4'd0);
        snap = 1'b1;
        @(posedge clock); #1;
        snap = 1'b0;
        // release while scan sits at the origin: that edge is frame tick 1
        resetn = 1'b1;
        @(posedge clock); #1;
        push_snap(2'd1, 4'd0);
        snap = 1'b1;
        x = 11'd5; y = 11'd5; aimX = 11'd0; aimY = 11'd0;
        @(posedge clock); #1;
        snap = 1'b0;
        @(posedge clock); #1;

        // (300,200) held: fire at tick 11
        for (int k = 1; k <= 9; k++) frame(11'd300, 11'd200, 2'd1, 4'(k));
        exp_lx = 11'd300; exp_ly = 11'd200;
        fire_q.push_back({11'd300, 11'd200});
        frame(11'd300, 11'd200, 2'd2, 4'd0);

        // 30 cooldown ticks, then re-arm and a second shot
        for (int i = 1; i <= 30; i++) frame(11'd300, 11'd200, (i == 30) ? 2'd0 : 2'd3, 4'd0);
        frame(11'd300, 11'd200, 2'd1, 4'd0);
        for (int k = 1; k <= 9; k++) frame(11'd300, 11'd200, 2'd1, 4'(k));
        fire_q.push_back({11'd300, 11'd200});
        frame(11'd300, 11'd200, 2'd2, 4'd0);
        frame(11'd300, 11'd200, 2'd3, 4'd0);
        frame(11'd300, 11'd200, 2'd3, 4'd0);
        pulse_reset();

        // target lost while tracking
        frame(11'd300, 11'd200, 2'd1, 4'd0);
        frame(11'd305, 11'd195, 2'd1, 4'd1);
        frame(11'd0, 11'd0, 2'd0, 4'd0);

        // jitter of 20 px never counts as steady
        for (int i = 0; i < 30; i++) frame((i % 2 == 1) ? 11'd320 : 11'd300, 11'd200, 2'd1, 4'd0);
        frame(11'd0, 11'd0, 2'd0, 4'd0);

        // 16 px on both axes is still steady
        frame(11'd300, 11'd200, 2'd1, 4'd0);
        for (int k = 1; k <= 9; k++) frame(11'd316, 11'd216, 2'd1, 4'(k));
        exp_lx = 11'd300; exp_ly = 11'd200;
        fire_q.push_back({11'd300, 11'd200});
        frame(11'd316, 11'd216, 2'd2, 4'd0);
        frame(11'd316, 11'd216, 2'd3, 4'd0);
        pulse_reset();

        // reset at dwellCount 7: a full new dwell is needed
        frame(11'd300, 11'd200, 2'd1, 4'd0);
        for (int k = 1; k <= 7; k++) frame(11'd300, 11'd200, 2'd1, 4'(k));
        pulse_reset();
        frame(11'd300, 11'd200, 2'd1, 4'd0);
        for (int k = 1; k <= 9; k++) frame(11'd300, 11'd200, 2'd1, 4'(k));
        exp_lx = 11'd300; exp_ly = 11'd200;
        fire_q.push_back({11'd300, 11'd200});
        frame(11'd300, 11'd200, 2'd2, 4'd0);
        pulse_reset();

        // crosshair around anchor (100,50): 33 pixels, each reported one clock late
        frame(11'd100, 11'd50, 2'd1, 4'd0);
        xh_en = 1'b1;
        for (int yy = 30; yy <= 70; yy++) begin
            for (int xx = 80; xx <= 120; xx++) begin
                x = 11'(xx); y = 11'(yy);
                if ((xx == 100 && yy >= 42 && yy <= 58) || (yy == 50 && xx >= 92 && xx <= 108))
                    xh_q.push_back({11'(xx), 11'(yy)});
                @(posedge clock); #1;
            end
        end
        x = 11'd5; y = 11'd5;
        @(posedge clock); #1;
        @(posedge clock); #1;
        xh_en = 1'b0;
        done = 1'b1;
    end

endmodule
